// File: rtl/gpo_core_queued.sv
// Timed GPO channel core: applies destination-matched timed words to a 64-bit output,
// queueing words in order while the downstream driver is busy instead of erroring.
module gpo_core_queued #(
  parameter logic [15:0] DEST_VAL       = 16'h0,
  parameter int          CHANNEL_LENGTH = 12,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic                              CLK100MHZ,
  input  logic                              reset_n,
  input  logic                              override_en,
  input  logic                              selected_en,
  input  logic [63:0]                       override_value,
  input  logic                              counter_matched,
  input  logic [127:0]                      gpo_in,
  input  logic                              busy,
  input  logic                              flush,
  output logic                              selected,
  output logic [127:0]                      error_data,
  output logic                              overrided,
  output logic                              busy_error,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              fifo_full,
  output logic [63:0]                       gpo_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0]          DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [CHANNEL_LENGTH-1:0] DEST_CMP = DEST_VAL[CHANNEL_LENGTH-1:0];

  function automatic logic dest_hit(input logic [127:0] w);
    return w[96 +: CHANNEL_LENGTH] == DEST_CMP;
  endfunction

  function automatic logic [63:0] out_proj(input logic [127:0] w);
    return {w[127:96], w[31:0]};
  endfunction

  logic [127:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [LVL_W-1:0] level_p1, level_nxt;
  logic [127:0]     out_buf_p1;
  logic [63:0]      ovr_value_p1;
  logic             ovr_state_p1;

  logic dest_check, accept, collision, q_empty;
  logic pop, bypass, push_req, push_room, push_ok, drop;

  // Stage p0: request decode against the current queue state
  always_comb begin
    dest_check = dest_hit(gpo_in) & counter_matched;
    accept     = dest_check & ~override_en;
    collision  = dest_check & override_en;
    q_empty    = (level_p1 == '0);
    pop        = ~busy & ~q_empty & ~flush;
    bypass     = ~busy & q_empty & accept;
    push_req   = accept & (busy | ~q_empty);
    // A full queue still takes a word when the head leaves in the same cycle
    push_room  = (level_p1 != DEPTH_L) | pop;
    push_ok    = push_req & ~flush & push_room;
    drop       = push_req & ~flush & ~push_room;
  end

  always_comb begin
    level_nxt = level_p1;
    if (flush) begin
      level_nxt = '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   level_nxt = level_p1 + LVL_W'(1);
        2'b01:   level_nxt = level_p1 - LVL_W'(1);
        default: level_nxt = level_p1;
      endcase
    end
  end

  // Queue storage carries no reset; validity is tracked by the pointers and level
  always_ff @(posedge CLK100MHZ) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_p1] <= gpo_in;
    end
  end

  // Stage p1: queue control, output buffer and status pulses
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_p1 <= '0;
      wr_ptr_p1 <= '0;
      level_p1  <= '0;
    end else if (flush) begin
      rd_ptr_p1 <= '0;
      wr_ptr_p1 <= '0;
      level_p1  <= '0;
    end else begin
      if (pop) begin
        rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
      end
      if (push_ok) begin
        wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
      end
      level_p1 <= level_nxt;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      out_buf_p1 <= '0;
    end else if (pop) begin
      out_buf_p1 <= fifo_mem[rd_ptr_p1];
    end else if (bypass) begin
      out_buf_p1 <= gpo_in;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      ovr_value_p1 <= '0;
      ovr_state_p1 <= 1'b0;
    end else begin
      if (override_en & ~busy) begin
        ovr_value_p1 <= override_value;
      end
      ovr_state_p1 <= override_en & ~busy;
    end
  end

  // Collision and overflow are exclusive per word since accept excludes override_en
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      selected   <= 1'b0;
      overrided  <= 1'b0;
      busy_error <= 1'b0;
      error_data <= '0;
    end else begin
      selected   <= pop | bypass | (selected_en & ~busy);
      overrided  <= collision;
      busy_error <= drop;
      if (collision | drop) begin
        error_data <= gpo_in;
      end
    end
  end

  assign fifo_level = level_p1;
  assign fifo_full  = (level_p1 == DEPTH_L);
  assign gpo_out    = ovr_state_p1 ? ovr_value_p1 : out_proj(out_buf_p1);

endmodule

// File: tb/tb_gpo_core_queued.sv
// Directed self-checking bench for gpo_core_queued with hand-computed expectations.
module tb_gpo_core_queued;

  logic         CLK100MHZ = 1'b0;
  logic         reset_n;
  logic         override_en;
  logic         selected_en;
  logic [63:0]  override_value;
  logic         counter_matched;
  logic [127:0] gpo_in;
  logic         busy;
  logic         flush;
  logic         selected;
  logic [127:0] error_data;
  logic         overrided;
  logic         busy_error;
  logic [2:0]   fifo_level;
  logic         fifo_full;
  logic [63:0]  gpo_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] w [8];
  logic [127:0] last_applied;

  gpo_core_queued #(.DEST_VAL(16'h0), .CHANNEL_LENGTH(12), .FIFO_DEPTH(4)) dut (
    .CLK100MHZ      (CLK100MHZ),
    .reset_n        (reset_n),
    .override_en    (override_en),
    .selected_en    (selected_en),
    .override_value (override_value),
    .counter_matched(counter_matched),
    .gpo_in         (gpo_in),
    .busy           (busy),
    .flush          (flush),
    .selected       (selected),
    .error_data     (error_data),
    .overrided      (overrided),
    .busy_error     (busy_error),
    .fifo_level     (fifo_level),
    .fifo_full      (fifo_full),
    .gpo_out        (gpo_out)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] hi, input logic [31:0] lo);
    return {hi, 64'h0123_4567_89AB_CDEF, lo};
  endfunction

  function automatic logic [63:0] proj(input logic [127:0] x);
    return {x[127:96], x[31:0]};
  endfunction

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic idle_inputs();
    override_en     = 1'b0;
    selected_en     = 1'b0;
    override_value  = '0;
    counter_matched = 1'b0;
    gpo_in          = '0;
    busy            = 1'b0;
    flush           = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      w[i] = mk(32'hC000_0000 + (i << 16), 32'h1000_0000 + i);
    end
    idle_inputs();
    reset_n = 1'b0;
    #23;
    check("rst_gpo_out", gpo_out, 0);
    check("rst_selected", selected, 0);
    check("rst_level", fifo_level, 0);
    check("rst_full", fifo_full, 0);
    check("rst_error_data", error_data, 0);
    check("rst_pulses", {overrided, busy_error}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // T1: bypass path
    counter_matched = 1'b1;
    gpo_in = 128'hAAAA_0000_0000_0000_0000_0000_1234_5678;
    tick();
    counter_matched = 1'b0;
    check("t1_gpo_out", gpo_out, 64'hAAAA0000_12345678);
    check("t1_selected", selected, 1);
    check("t1_level", fifo_level, 0);
    tick();
    check("t1_selected_off", selected, 0);
    last_applied = 128'hAAAA_0000_0000_0000_0000_0000_1234_5678;

    // Wrong destination is ignored
    counter_matched = 1'b1;
    gpo_in = mk(32'hBBBB_0001, 32'h5555_5555);
    tick();
    counter_matched = 1'b0;
    check("dest_miss_selected", selected, 0);
    check("dest_miss_gpo_out", gpo_out, proj(last_applied));

    // T2: queue three words while busy, then drain in order
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      counter_matched = 1'b1;
      gpo_in = w[i];
      tick();
      check("t2_no_busy_error", busy_error, 0);
    end
    counter_matched = 1'b0;
    check("t2_level", fifo_level, 3);
    check("t2_no_select_while_busy", selected, 0);
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_drain_out", gpo_out, proj(w[i]));
      check("t2_drain_sel", selected, 1);
      check("t2_drain_level", fifo_level, 3'(2 - i));
    end
    tick();
    check("t2_sel_end", selected, 0);

    // T3: overflow drops the fifth word
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      counter_matched = 1'b1;
      gpo_in = w[i + 3];
      tick();
    end
    check("t3_level", fifo_level, 4);
    check("t3_full", fifo_full, 1);
    check("t3_no_err_yet", busy_error, 0);
    gpo_in = w[7];
    tick();
    check("t3_busy_error", busy_error, 1);
    check("t3_error_data", error_data, w[7]);
    check("t3_level_hold", fifo_level, 4);

    // T4: full queue, pop and push in the same cycle
    busy = 1'b0;
    gpo_in = mk(32'hE000_0000, 32'h4444_0004);
    tick();
    counter_matched = 1'b0;
    check("t4_busy_error", busy_error, 0);
    check("t4_level", fifo_level, 4);
    check("t4_full", fifo_full, 1);
    check("t4_out_head", gpo_out, proj(w[3]));
    check("t4_sel", selected, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_drain_out", gpo_out, proj(w[i + 4]));
      check("t4_drain_level", fifo_level, 3'(3 - i));
    end
    tick();
    check("t4_tail_out", gpo_out, 64'hE0000000_44440004);
    check("t4_tail_level", fifo_level, 0);
    check("t4_error_data_hold", error_data, w[7]);
    last_applied = mk(32'hE000_0000, 32'h4444_0004);
    tick();
    check("t4_sel_end", selected, 0);

    // T5: override and collision
    override_en = 1'b1;
    override_value = 64'hDEAD_BEEF_0000_0001;
    tick();
    check("t5_ovr_out", gpo_out, 64'hDEAD_BEEF_0000_0001);
    counter_matched = 1'b1;
    gpo_in = mk(32'hF000_0000, 32'h7777_7777);
    tick();
    counter_matched = 1'b0;
    check("t5_overrided", overrided, 1);
    check("t5_error_data", error_data, mk(32'hF000_0000, 32'h7777_7777));
    check("t5_level", fifo_level, 0);
    check("t5_no_sel", selected, 0);
    check("t5_ovr_out_hold", gpo_out, 64'hDEAD_BEEF_0000_0001);
    tick();
    check("t5_overrided_off", overrided, 0);
    override_en = 1'b0;
    tick();
    check("t5_release_out", gpo_out, proj(last_applied));

    // Forced select with no data
    selected_en = 1'b1;
    tick();
    selected_en = 1'b0;
    check("force_sel", selected, 1);
    check("force_sel_out", gpo_out, proj(last_applied));

    // T6: flush with a same-cycle matched word
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      counter_matched = 1'b1;
      gpo_in = w[i];
      tick();
    end
    check("t6_level", fifo_level, 3);
    busy = 1'b0;
    flush = 1'b1;
    gpo_in = w[5];
    tick();
    flush = 1'b0;
    counter_matched = 1'b0;
    check("t6_flush_level", fifo_level, 0);
    check("t6_flush_pulses", {selected, busy_error, overrided}, 0);
    check("t6_flush_out", gpo_out, proj(last_applied));
    tick();
    check("t6_after_flush_sel", selected, 0);

    // Reset mid-drain
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      counter_matched = 1'b1;
      gpo_in = w[i];
      tick();
    end
    counter_matched = 1'b0;
    busy = 1'b0;
    tick();
    check("t6_drain_started", gpo_out, proj(w[0]));
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_out", gpo_out, 0);
    check("t6_async_level", fifo_level, 0);
    check("t6_async_sel", selected, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_post_rst_sel", selected, 0);
      check("t6_post_rst_level", fifo_level, 0);
      check("t6_post_rst_out", gpo_out, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
